// File: rtl/lcd_scanout.sv
// rtl/lcd_scanout.sv - DMG LCD scan-out: reads the 2-bit frame from VRAM and drives the panel timing
//
// Ports:
//   vramclk      single clock for the whole block
//   rst_n        asynchronous active-low reset
//   vramrdaddr   VRAM read address {ypos[7:0], xpos[7:0]}, held between reads
//   vramrden     VRAM read enable, one cycle per active pixel slot
//   vramrddata   VRAM read data, valid the cycle after vramrden
//   lcd_cp       pixel clock, panel samples lcd_d on its rising edge
//   lcd_d        pixel data LD1:LD0
//   lcd_st       line-start marker (slot 0 of active lines)
//   lcd_cpl      line latch (first blank slot of active lines)
//   lcd_s        vertical sync (whole of line 0)
//   lcd_fr       drive polarity, toggles at the start of every line
//   frame_start  one-cycle pulse at the start of each frame
module lcd_scanout #(
    parameter int H_ACTIVE = 160,
    parameter int H_BLANK  = 48,
    parameter int V_ACTIVE = 144,
    parameter int V_BLANK  = 10,
    parameter int CLK_DIV  = 4,
    parameter int INVERT   = 0
) (
    input  logic        vramclk,
    input  logic        rst_n,
    output logic [15:0] vramrdaddr,
    output logic        vramrden,
    input  logic [1:0]  vramrddata,
    output logic        lcd_cp,
    output logic [1:0]  lcd_d,
    output logic        lcd_st,
    output logic        lcd_cpl,
    output logic        lcd_s,
    output logic        lcd_fr,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_SHOW = DW'(2);
    localparam logic [DW-1:0] CP_FIRST = DW'(CLK_DIV / 2 + 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);

    // run_q is clear for exactly one edge after reset so that the first edge
    // presents slot (0,0,0) instead of advancing past it.
    logic          run_q;
    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;

    logic [15:0]   addr_q, addr_d;
    logic          rden_q, rden_d;
    logic          cp_q, cp_d;
    logic [1:0]    pix_q, pix_d;
    logic          st_q, st_d;
    logic          cpl_q, cpl_d;
    logic          s_q, s_d;
    logic          fr_q, fr_d;
    logic          fs_q, fs_d;

    logic          active_d;
    logic          line_start_d;
    logic [1:0]    pix_in;

    assign pix_in = (INVERT != 0) ? ~vramrddata : vramrddata;

    always_comb begin
        div_d  = div_q;
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (run_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (hpos_q == H_LAST) begin
                    hpos_d = '0;
                    vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
                end else begin
                    hpos_d = hpos_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Outputs are derived from the next-state counters so that, once registered,
    // they line up with the counter values held in the same cycle.
    always_comb begin
        active_d     = (hpos_d < H_ACT) && (vpos_d < V_ACT);
        line_start_d = (div_d == '0) && (hpos_d == '0);
        rden_d       = active_d && (div_d == '0);
        addr_d       = rden_d ? {8'(vpos_d), 8'(hpos_d)} : addr_q;
        cp_d         = active_d && (div_d >= CP_FIRST);
        st_d         = active_d && (hpos_d == '0);
        cpl_d        = (hpos_d == H_ACT) && (vpos_d < V_ACT);
        s_d          = (vpos_d == '0);
        fr_d         = line_start_d ? ~fr_q : fr_q;
        fs_d         = line_start_d && (vpos_d == '0);
        pix_d        = pix_q;
        // Moving into div 2 means the current cycle is div 1, when the read
        // data is valid; blank slots load 0 instead.
        if (div_d == DIV_SHOW) begin
            pix_d = active_d ? pix_in : 2'b00;
        end
    end

    always_ff @(posedge vramclk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            div_q  <= '0;
            hpos_q <= '0;
            vpos_q <= '0;
            addr_q <= '0;
            rden_q <= 1'b0;
            cp_q   <= 1'b0;
            pix_q  <= 2'b00;
            st_q   <= 1'b0;
            cpl_q  <= 1'b0;
            s_q    <= 1'b0;
            fr_q   <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            div_q  <= div_d;
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            addr_q <= addr_d;
            rden_q <= rden_d;
            cp_q   <= cp_d;
            pix_q  <= pix_d;
            st_q   <= st_d;
            cpl_q  <= cpl_d;
            s_q    <= s_d;
            fr_q   <= fr_d;
            fs_q   <= fs_d;
        end
    end

    assign vramrdaddr  = addr_q;
    assign vramrden    = rden_q;
    assign lcd_cp      = cp_q;
    assign lcd_d       = pix_q;
    assign lcd_st      = st_q;
    assign lcd_cpl     = cpl_q;
    assign lcd_s       = s_q;
    assign lcd_fr      = fr_q;
    assign frame_start = fs_q;

endmodule
